// File: rtl/ram_rd_streamer.sv
// Read-side streamer for the vector RAM.
// Accepts a (base, length) command, walks consecutive RAM addresses with wrap-around,
// registers each vector and presents it on a valid/ready stream. Backpressure stalls
// the walk without dropping or repeating beats.
module ram_rd_streamer #(
    parameter int unsigned VEC_WIDTH  = 264,
    parameter int unsigned ARR_DEPTH  = 2048,
    parameter int unsigned ADDR_WIDTH = $clog2(ARR_DEPTH),
    parameter int unsigned LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [LEN_WIDTH-1:0]  i_len,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    input  logic [VEC_WIDTH-1:0]  i_ram_data,
    output logic [VEC_WIDTH-1:0]  o_data,
    output logic                  o_valid,
    output logic                  o_last,
    input  logic                  i_ready
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StStream = 2'd1,
        StDone   = 2'd2
    } state_e;

    localparam logic [LEN_WIDTH-1:0]  MaxLen   = LEN_WIDTH'(ARR_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(ARR_DEPTH - 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic [VEC_WIDTH-1:0]  data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;

    logic                  fetch;
    logic                  accept;
    logic [LEN_WIDTH-1:0]  len_clamped;
    logic [ADDR_WIDTH-1:0] addr_inc;

    // Handshake decode, length clamp and wrapping address increment.
    always_comb begin
        accept      = valid_q & i_ready;
        // A new beat may be loaded when the output slot is empty or is being drained.
        fetch       = (state_q == StStream) && (rem_q != '0) && (!valid_q || i_ready);
        len_clamped = (i_len > MaxLen) ? MaxLen : i_len;
        // Explicit compare keeps the wrap correct for non-power-of-2 depths.
        addr_inc    = (addr_q == LastAddr) ? '0 : addr_q + ADDR_WIDTH'(1);
    end

    // Next-state logic for the burst FSM and the output beat register.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;

        case (state_q)
            StIdle: begin
                if (i_start) begin
                    addr_d  = i_base_addr;
                    rem_d   = len_clamped;
                    state_d = (len_clamped == '0) ? StDone : StStream;
                end
            end

            StStream: begin
                if (fetch) begin
                    // Capture at the fetch edge; later RAM writes cannot alter this beat.
                    data_d  = i_ram_data;
                    valid_d = 1'b1;
                    last_d  = (rem_q == LEN_WIDTH'(1));
                    addr_d  = addr_inc;
                    rem_d   = rem_q - LEN_WIDTH'(1);
                end else if (accept) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                end

                // The final beat leaves the slot empty because rem is already zero.
                if (accept && last_q) begin
                    state_d = StDone;
                end
            end

            StDone: begin
                valid_d = 1'b0;
                last_d  = 1'b0;
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset; reset aborts any burst.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            rem_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    // Status and stream outputs come straight from registers.
    always_comb begin
        o_busy     = (state_q == StStream);
        o_done     = (state_q == StDone);
        o_ram_addr = addr_q;
        o_data     = data_q;
        o_valid    = valid_q;
        o_last     = last_q;
    end

endmodule

// File: tb/tb_ram_rd_streamer.sv
// Directed bench for ram_rd_streamer: RAM model, bursts with/without backpressure,
// wrap, zero and oversized length, ignored mid-burst start and reset mid-burst.
module tb_ram_rd_streamer;

    localparam int unsigned VW = 264;
    localparam int unsigned AD = 2048;
    localparam int unsigned AW = 11;
    localparam int unsigned LW = 12;

    logic          clk = 1'b0;
    logic          i_rst;
    logic          i_start;
    logic [AW-1:0] i_base_addr;
    logic [LW-1:0] i_len;
    logic          o_busy;
    logic          o_done;
    logic [AW-1:0] o_ram_addr;
    logic [VW-1:0] i_ram_data;
    logic [VW-1:0] o_data;
    logic          o_valid;
    logic          o_last;
    logic          i_ready;

    logic [VW-1:0] mem [AD];
    assign i_ram_data = mem[o_ram_addr];

    int n_checks = 0;
    int n_errors = 0;
    bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    always #5 clk = ~clk;

    ram_rd_streamer #(
        .VEC_WIDTH (VW),
        .ARR_DEPTH (AD)
    ) u_dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_start     (i_start),
        .i_base_addr (i_base_addr),
        .i_len       (i_len),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_ram_addr  (o_ram_addr),
        .i_ram_data  (i_ram_data),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_last      (o_last),
        .i_ready     (i_ready)
    );

    task automatic check_eq(input string tag, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Distinct pattern in both ends of the vector so width faults show up.
    function automatic logic [VW-1:0] vec(input int a);
        logic [VW-1:0] v;
        v = '0;
        v[15:0] = 16'(a);
        v[VW-1 -: 16] = ~16'(a);
        return v;
    endfunction

    task automatic preload();
        for (int i = 0; i < AD; i++) mem[i] = vec(i);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one command and scoreboard the resulting stream.
    // mode 0: ready held high; mode 1: ready follows pat[]. inj: cycle to pulse a stray start.
    task automatic stream(input int base, input int len, input int mode, input int inj,
                          input bit poke, output int beats, output int first_cyc,
                          output int done_cyc);
        int            exp_n;
        int            exp_addr;
        int            limit;
        bit            prev_stall;
        bit            busy_bad;
        bit            saw_done;
        logic [VW-1:0] pd;
        logic          pl;
        logic [AW-1:0] pa;

        exp_n       = (len > int'(AD)) ? int'(AD) : len;
        limit       = exp_n * 4 + 20;
        i_base_addr = AW'(base);
        i_len       = LW'(len);
        i_start     = 1'b1;
        tick();
        i_start     = 1'b0;
        beats       = 0;
        first_cyc   = -1;
        done_cyc    = -1;
        exp_addr    = base;
        prev_stall  = 1'b0;
        busy_bad    = 1'b0;
        saw_done    = 1'b0;
        pd          = '0;
        pl          = 1'b0;
        pa          = '0;
        check_eq("valid_after_start", VW'(o_valid), VW'(1'b0));

        for (int cyc = 0; cyc < limit; cyc++) begin
            i_ready = (mode == 0) ? 1'b1 : pat[cyc % 6];
            i_start = (cyc == inj);
            if (cyc == inj) begin
                i_base_addr = AW'(100);
                i_len       = LW'(2);
            end
            if (o_done) begin
                saw_done = 1'b1;
                done_cyc = cyc;
                check_eq("valid_in_done", VW'(o_valid), VW'(1'b0));
                check_eq("busy_in_done", VW'(o_busy), VW'(1'b0));
                break;
            end
            if (!o_busy) busy_bad = 1'b1;
            if (prev_stall) begin
                check_eq("stall_data", o_data, pd);
                check_eq("stall_last", VW'(o_last), VW'(pl));
                check_eq("stall_addr", VW'(o_ram_addr), VW'(pa));
            end
            if (o_valid && i_ready) begin
                if (first_cyc < 0) first_cyc = cyc;
                check_eq("beat_data", o_data, vec(exp_addr));
                check_eq("beat_last", VW'(o_last), VW'(beats == exp_n - 1));
                beats++;
                exp_addr = (exp_addr == int'(AD) - 1) ? 0 : exp_addr + 1;
            end
            prev_stall = o_valid && !i_ready;
            pd = o_data;
            pl = o_last;
            pa = o_ram_addr;
            // Overwrite the held beat's source; the registered copy must not change.
            if (poke && prev_stall) mem[exp_addr] = '1;
            tick();
        end
        i_start = 1'b0;
        i_ready = 1'b1;

        check_eq("done_seen", VW'(saw_done), VW'(1'b1));
        check_eq("beat_count", VW'(beats), VW'(exp_n));
        check_eq("busy_during_burst", VW'(busy_bad), VW'(1'b0));
        if (saw_done) begin
            tick();
            check_eq("done_one_cycle", VW'(o_done), VW'(1'b0));
            check_eq("idle_busy", VW'(o_busy), VW'(1'b0));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int beats;
        int first_cyc;
        int done_cyc;

        i_rst       = 1'b1;
        i_start     = 1'b0;
        i_base_addr = '0;
        i_len       = '0;
        i_ready     = 1'b1;
        preload();
        tick();
        tick();
        check_eq("rst_valid", VW'(o_valid), VW'(1'b0));
        check_eq("rst_busy", VW'(o_busy), VW'(1'b0));
        check_eq("rst_done", VW'(o_done), VW'(1'b0));
        check_eq("rst_last", VW'(o_last), VW'(1'b0));
        check_eq("rst_data", o_data, '0);
        check_eq("rst_addr", VW'(o_ram_addr), '0);
        i_rst = 1'b0;
        tick();

        // Basic burst, ready held high.
        stream(4, 4, 0, -1, 1'b0, beats, first_cyc, done_cyc);
        check_eq("t1_first_cyc", VW'(first_cyc), VW'(1));
        check_eq("t1_done_cyc", VW'(done_cyc), VW'(5));

        // Same burst with backpressure and RAM writes while stalled.
        stream(4, 4, 1, -1, 1'b1, beats, first_cyc, done_cyc);
        preload();

        // Address wrap at the top of the RAM.
        stream(2046, 4, 0, -1, 1'b0, beats, first_cyc, done_cyc);
        check_eq("wrap_done_cyc", VW'(done_cyc), VW'(5));

        // Zero length: done straight after start, no beats.
        stream(0, 0, 0, -1, 1'b0, beats, first_cyc, done_cyc);
        check_eq("len0_done_cyc", VW'(done_cyc), VW'(0));

        // Oversized length clamps to the RAM depth.
        stream(0, 3000, 0, -1, 1'b0, beats, first_cyc, done_cyc);
        check_eq("clamp_done_cyc", VW'(done_cyc), VW'(AD + 1));

        // Stray start mid-burst is ignored.
        stream(20, 6, 0, 3, 1'b0, beats, first_cyc, done_cyc);
        check_eq("inj_done_cyc", VW'(done_cyc), VW'(7));

        // Reset after two of eight beats have been accepted.
        i_ready     = 1'b1;
        i_base_addr = AW'(0);
        i_len       = LW'(8);
        i_start     = 1'b1;
        tick();
        i_start = 1'b0;
        tick();
        tick();
        tick();
        check_eq("pre_rst_beat", o_data, vec(2));
        i_rst = 1'b1;
        tick();
        check_eq("abort_valid", VW'(o_valid), VW'(1'b0));
        check_eq("abort_busy", VW'(o_busy), VW'(1'b0));
        check_eq("abort_addr", VW'(o_ram_addr), '0);
        check_eq("abort_data", o_data, '0);
        check_eq("abort_last", VW'(o_last), VW'(1'b0));
        check_eq("abort_done", VW'(o_done), VW'(1'b0));
        i_rst = 1'b0;
        tick();
        check_eq("abort_no_done", VW'(o_done), VW'(1'b0));

        // Fresh command after the abort.
        stream(10, 3, 0, -1, 1'b0, beats, first_cyc, done_cyc);
        check_eq("post_rst_done_cyc", VW'(done_cyc), VW'(4));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
